bus_mux_reg: RTL and testbench

Parametrised, registered successor to the processor's BusWires multiplexer. It selects one of NREGS general registers, DIN, G, constant 0 or constant 1 onto a WIDTH-bit bus, registered on Clock. It holds the last value when no source is enabled, detects multi-source conflicts and reports them through flags and a saturating counter. It sits between the register file/G/DIN and every bus consumer (IR, A, R-loads).

---
 rtl/bus_mux_reg.sv | 122 ++++++++++++
 tb/tb_bus_mux_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_reg.sv
// Registered bus multiplexer with conflict detection and saturating counter.
// Define BUS_STRICT_EN to hold the bus (no priority resolution) on a conflict.
module bus_mux_reg #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int CNT_W = 8,
  localparam int SRC_W = $clog2(NREGS + 5),
  localparam logic [SRC_W-1:0] SRC_IDLE = '1
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic [NREGS-1:0]       Rout,
  input  logic                   DINout,
  input  logic                   Gout,
  input  logic                   Zout,
  input  logic                   Oneout,
  input  logic [NREGS*WIDTH-1:0] R_data,
  input  logic [WIDTH-1:0]       G_data,
  input  logic [WIDTH-1:0]       DIN_data,
  input  logic                   err_clr,
  output logic [WIDTH-1:0]       BusWires,
  output logic                   bus_valid,
  output logic [SRC_W-1:0]       bus_src,
  output logic                   conflict,
  output logic                   err_sticky,
  output logic [CNT_W-1:0]       conflict_cnt
);

  localparam logic [SRC_W-1:0] SRC_DIN  = SRC_W'(NREGS);
  localparam logic [SRC_W-1:0] SRC_G    = SRC_W'(NREGS + 1);
  localparam logic [SRC_W-1:0] SRC_ZERO = SRC_W'(NREGS + 2);
  localparam logic [SRC_W-1:0] SRC_ONE  = SRC_W'(NREGS + 3);

  logic [SRC_W-1:0] n;
  logic [SRC_W-1:0] ridx;
  logic [WIDTH-1:0] rval;
  logic [WIDTH-1:0] sel_data;
  logic [SRC_W-1:0] sel_src;
  logic             multi;
  logic             take;

  // Descending scan so the lowest register index is the last to win.
  always_comb begin
    n    = SRC_W'(DINout) + SRC_W'(Gout)
         + SRC_W'(Zout) + SRC_W'(Oneout);
    ridx = '0;
    rval = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      n = n + SRC_W'(Rout[NREGS-1-i]);
      if (Rout[NREGS-1-i]) begin
        ridx = SRC_W'(i);
        rval = R_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    sel_data = BusWires;
    sel_src  = SRC_IDLE;
    priority case (1'b1)
      DINout: begin
        sel_data = DIN_data;
        sel_src  = SRC_DIN;
      end
      Gout: begin
        sel_data = G_data;
        sel_src  = SRC_G;
      end
      Oneout: begin
        sel_data = WIDTH'(1);
        sel_src  = SRC_ONE;
      end
      Zout: begin
        sel_data = '0;
        sel_src  = SRC_ZERO;
      end
      (|Rout): begin
        sel_data = rval;
        sel_src  = ridx;
      end
      default: ;
    endcase
  end

  assign multi = (n > SRC_W'(1));
`ifdef BUS_STRICT_EN
  assign take = (n == SRC_W'(1));
`else
  assign take = (n != '0);
`endif

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      BusWires     <= '0;
      bus_valid    <= 1'b0;
      bus_src      <= SRC_IDLE;
      conflict     <= 1'b0;
      err_sticky   <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (take) begin
        BusWires  <= sel_data;
        bus_valid <= 1'b1;
        bus_src   <= sel_src;
      end else begin
        bus_valid <= 1'b0;
        bus_src   <= SRC_IDLE;
      end
      conflict <= multi;
      // Clear first; a same-cycle conflict then counts once.
      if (err_clr) begin
        err_sticky   <= multi;
        conflict_cnt <= multi ? CNT_W'(1) : '0;
      end else if (multi) begin
        err_sticky <= 1'b1;
        if (conflict_cnt != '1)
          conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed self-checking bench for bus_mux_reg.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_bus_mux_reg;

`ifdef BUS_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [7:0]  Rout;
  logic        DINout, Gout, Zout, Oneout;
  logic [127:0] R_data;
  logic [15:0] G_data, DIN_data;
  logic        err_clr;

  logic [15:0] bus, bus2;
  logic        valid, valid2;
  logic [3:0]  src, src2;
  logic        conf, conf2;
  logic        err, err2;
  logic [7:0]  cnt;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] held;

  bus_mux_reg dut (
    .Clock(Clock), .Resetn(Resetn), .Rout(Rout),
    .DINout(DINout), .Gout(Gout), .Zout(Zout),
    .Oneout(Oneout), .R_data(R_data), .G_data(G_data),
    .DIN_data(DIN_data), .err_clr(err_clr),
    .BusWires(bus), .bus_valid(valid), .bus_src(src),
    .conflict(conf), .err_sticky(err),
    .conflict_cnt(cnt)
  );

  bus_mux_reg #(.CNT_W(2)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .Rout(Rout),
    .DINout(DINout), .Gout(Gout), .Zout(Zout),
    .Oneout(Oneout), .R_data(R_data), .G_data(G_data),
    .DIN_data(DIN_data), .err_clr(err_clr),
    .BusWires(bus2), .bus_valid(valid2), .bus_src(src2),
    .conflict(conf2), .err_sticky(err2),
    .conflict_cnt(cnt2)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic exp_out(input string tag,
                         input logic [15:0] b,
                         input logic v,
                         input logic [3:0] s,
                         input logic c,
                         input logic e,
                         input logic [7:0] k,
                         input logic [1:0] k2);
    chk({tag, ":bus"}, 32'(bus), 32'(b));
    chk({tag, ":valid"}, 32'(valid), 32'(v));
    chk({tag, ":src"}, 32'(src), 32'(s));
    chk({tag, ":conflict"}, 32'(conf), 32'(c));
    chk({tag, ":err"}, 32'(err), 32'(e));
    chk({tag, ":cnt"}, 32'(cnt), 32'(k));
    chk({tag, ":err2"}, 32'(err2), 32'(e));
    chk({tag, ":cnt2"}, 32'(cnt2), 32'(k2));
  endtask

  task automatic exp_single(input string tag,
                            input logic [15:0] b,
                            input logic [3:0] s,
                            input logic e,
                            input logic [7:0] k,
                            input logic [1:0] k2);
    held = b;
    exp_out(tag, b, 1'b1, s, 1'b0, e, k, k2);
  endtask

  task automatic exp_idle(input string tag,
                          input logic e,
                          input logic [7:0] k,
                          input logic [1:0] k2);
    exp_out(tag, held, 1'b0, 4'd15, 1'b0, e, k, k2);
  endtask

  task automatic exp_conf(input string tag,
                          input logic [15:0] b,
                          input logic [3:0] s,
                          input logic [7:0] k,
                          input logic [1:0] k2);
    if (!STRICT) held = b;
    exp_out(tag, held, !STRICT, STRICT ? 4'd15 : s,
            1'b1, 1'b1, k, k2);
  endtask

  task automatic sel(input logic [7:0] r, input logic d,
                     input logic g, input logic z,
                     input logic o);
    Rout = r; DINout = d; Gout = g; Zout = z; Oneout = o;
  endtask

  initial begin
    Resetn = 1'b0;
    err_clr = 1'b0;
    sel(8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      R_data[i*16 +: 16] = 16'(i * 16'h1111);
    R_data[3*16 +: 16] = 16'h1234;
    G_data = 16'h0F0F;
    DIN_data = 16'hBEEF;
    held = 16'h0000;

    step();
    exp_out("rst", 16'h0, 0, 4'd15, 0, 0, 8'd0, 2'd0);
    Resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_idle("idle", 0, 8'd0, 2'd0);
    end

    sel(8'b0001_0000, 0, 0, 0, 0);
    step();
    exp_single("r3", 16'h1234, 4'd3, 0, 8'd0, 2'd0);
    sel(8'h00, 0, 0, 0, 1);
    step();
    exp_single("one", 16'h0001, 4'd11, 0, 8'd0, 2'd0);
    sel(8'h00, 0, 0, 0, 0);
    step();
    exp_idle("hold1", 0, 8'd0, 2'd0);
    sel(8'h00, 0, 0, 1, 0);
    step();
    exp_single("zero", 16'h0000, 4'd10, 0, 8'd0, 2'd0);

    sel(8'b1000_0000, 1, 1, 0, 0);
    step();
    exp_conf("pri", 16'hBEEF, 4'd8, 8'd1, 2'd1);
    sel(8'h00, 0, 0, 0, 0);
    step();
    exp_idle("hold2", 1, 8'd1, 2'd1);

    sel(8'b0010_0100, 0, 0, 0, 0);
    step();
    exp_conf("r2r5", 16'h2222, 4'd2, 8'd2, 2'd2);
    sel(8'h00, 0, 0, 1, 1);
    step();
    exp_conf("onez", 16'h0001, 4'd11, 8'd3, 2'd3);
    sel(8'b0000_0001, 0, 1, 0, 0);
    step();
    exp_conf("gr7", 16'h0F0F, 4'd9, 8'd4, 2'd3);
    sel(8'b0000_0011, 0, 0, 0, 0);
    step();
    exp_conf("r6r7", 16'h6666, 4'd6, 8'd5, 2'd3);
    sel(8'h00, 0, 1, 0, 0);
    step();
    exp_single("g", 16'h0F0F, 4'd9, 1, 8'd5, 2'd3);

    sel(8'h00, 0, 0, 0, 0);
    err_clr = 1'b1;
    step();
    exp_idle("clr0", 0, 8'd0, 2'd0);
    err_clr = 1'b0;

    sel(8'h00, 1, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_conf("sat", 16'hBEEF, 4'd8, 8'(i),
               (i < 3) ? 2'(i) : 2'd3);
    end
    err_clr = 1'b1;
    step();
    exp_conf("clrconf", 16'hBEEF, 4'd8, 8'd1, 2'd1);
    sel(8'h00, 0, 0, 0, 0);
    step();
    exp_idle("clr", 0, 8'd0, 2'd0);
    err_clr = 1'b0;

    sel(8'b0010_0100, 0, 0, 0, 0);
    step();
    exp_conf("pre1", 16'h2222, 4'd2, 8'd1, 2'd1);
    step();
    exp_conf("pre2", 16'h2222, 4'd2, 8'd2, 2'd2);
    Resetn = 1'b0;
    sel(8'h00, 1, 0, 0, 0);
    step();
    held = 16'h0000;
    exp_out("rst2", 16'h0, 0, 4'd15, 0, 0, 8'd0, 2'd0);
    Resetn = 1'b1;
    sel(8'h00, 0, 0, 0, 0);
    step();
    exp_idle("post", 0, 8'd0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
